// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: FSM encodings, default operand width
// and the begin/end pulse handshake timing used by both multiplier and divider.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } mdu_state_t;

    // A request is accepted on the same edge that samples mult_begin in IDLE,
    // and completion is signalled by a pulse lasting exactly one cycle.
    localparam int MDU_ACCEPT_EDGES     = 0;
    localparam int MDU_END_PULSE_CYCLES = 1;

endpackage

// File: rtl/multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, fixed WIDTH-cycle
// latency, signed operands handled by magnitude multiply plus conditional negate.
module multiplier
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mult_begin,
    input  logic               mult_signed,
    input  logic [WIDTH-1:0]   mult_op1,
    input  logic [WIDTH-1:0]   mult_op2,
    output logic [2*WIDTH-1:0] product,
    output logic               mult_end,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    mdu_state_t         state_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CW-1:0]      cnt_reg;
    logic               neg_reg;
    logic [2*WIDTH-1:0] product_reg;
    logic               mult_end_reg;
    logic               busy_reg;

    logic [WIDTH-1:0]   op1_mag;
    logic [WIDTH-1:0]   op2_mag;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_next;

    // Negating the most negative value wraps back onto itself, which read as
    // unsigned is exactly the required magnitude 2^(WIDTH-1).
    assign op1_mag  = (mult_signed && mult_op1[WIDTH-1]) ? (~mult_op1 + 1'b1) : mult_op1;
    assign op2_mag  = (mult_signed && mult_op2[WIDTH-1]) ? (~mult_op2 + 1'b1) : mult_op2;
    assign addend   = mplier_reg[0] ? mcand_reg : '0;
    assign acc_next = acc_reg + addend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            neg_reg      <= 1'b0;
            product_reg  <= '0;
            mult_end_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    mult_end_reg <= 1'b0;
                    if (mult_begin) begin
                        mcand_reg  <= {{WIDTH{1'b0}}, op1_mag};
                        mplier_reg <= op2_mag;
                        neg_reg    <= mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
                        acc_reg    <= '0;
                        cnt_reg    <= CW'(WIDTH);
                        busy_reg   <= 1'b1;
                        state_reg  <= WORK;
                    end
                end
                WORK: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
                    mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
                    cnt_reg    <= cnt_reg - 1'b1;
                    // Final iteration: the accumulator sum is complete this cycle.
                    if (cnt_reg == CW'(1)) begin
                        product_reg  <= neg_reg ? (~acc_next + 1'b1) : acc_next;
                        mult_end_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign product  = product_reg;
    assign mult_end = mult_end_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_multiplier.sv
// Directed and random checks of the iterative multiplier: results, latency,
// handshake pulse timing and mid-run reset.
module tb_multiplier;

    logic        clk;
    logic        rst;
    logic        mult_begin;
    logic        mult_signed;
    logic [31:0] mult_op1;
    logic [31:0] mult_op2;
    logic [63:0] product;
    logic        mult_end;
    logic        busy;

    int checks = 0;
    int errors = 0;

    multiplier #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mult_begin (mult_begin),
        .mult_signed(mult_signed),
        .mult_op1   (mult_op1),
        .mult_op2   (mult_op2),
        .product    (product),
        .mult_end   (mult_end),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Runs one job from an idle bench; lat = edges from accept to mult_end, -1 on timeout.
    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [63:0] p, output int lat);
        @(negedge clk);
        mult_op1 = a; mult_op2 = b; mult_signed = s; mult_begin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mult_begin = 1'b0;
        lat = 0;
        while (!mult_end && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!mult_end) lat = -1;
        p = product;
    endtask

    task automatic check_job(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic [63:0] exp);
        logic [63:0] p;
        int lat;
        run_job(a, b, s, p, lat);
        checks++;
        if (p !== exp || lat != 32) begin
            errors++;
            $display("FAIL %s: product=%h latency=%0d, required product=%h latency=32", name, p, lat, exp);
        end else begin
            $display("ok   %s: %h * %h signed=%0d -> %h (latency %0d)", name, a, b, s, p, lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mult_begin = 1'b0; mult_signed = 1'b0; mult_op1 = '0; mult_op2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (product !== 64'd0 || busy !== 1'b0 || mult_end !== 1'b0) begin
            errors++;
            $display("FAIL reset: product=%h busy=%b mult_end=%b, required 0/0/0", product, busy, mult_end);
        end else $display("ok   reset: outputs cleared");
    endtask

    task automatic test_unsigned();
        check_job("unsigned_3x5", 32'h0000_0003, 32'h0000_0005, 1'b0, 64'h0000_0000_0000_000F);
        check_job("unsigned_fffe_x7", 32'hFFFF_FFFE, 32'h0000_0007, 1'b0, 64'h0000_0006_FFFF_FFF2);
    endtask

    task automatic test_signed();
        check_job("signed_m2x7", 32'hFFFF_FFFE, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2);
        check_job("signed_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
        check_job("signed_m1x0", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 64'h0000_0000_0000_0000);
    endtask

    task automatic test_extremes();
        check_job("signed_min_x_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        check_job("unsigned_max_x_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        check_job("signed_min_x_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000);
        check_job("zero_x_zero", 32'h0000_0000, 32'h0000_0000, 1'b0, 64'h0);
    endtask

    task automatic test_back_to_back();
        int lat;
        int busy_drops;
        @(negedge clk);
        mult_op1 = 32'h3; mult_op2 = 32'h5; mult_signed = 1'b0; mult_begin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mult_op1 = 32'h0000_1234; mult_op2 = 32'h0000_0010;
        lat = 0; busy_drops = 0;
        while (!mult_end && lat < 200) begin
            if (busy !== 1'b1) busy_drops++;
            @(posedge clk); lat++; @(negedge clk);
        end
        checks++;
        if (product !== 64'hF || lat != 32 || busy !== 1'b0 || busy_drops != 0) begin
            errors++;
            $display("FAIL b2b_first: product=%h lat=%0d busy=%b drops=%0d, required F/32/0/0",
                     product, lat, busy, busy_drops);
        end else $display("ok   b2b_first: product=%h latency=%0d", product, lat);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mult_end !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: mult_end=%b busy=%b, required 0/1", mult_end, busy);
        end else $display("ok   b2b_accept: second job accepted at mult_end edge");
        lat = 0; busy_drops = 0;
        while (!mult_end && lat < 200) begin
            if (busy !== 1'b1) busy_drops++;
            if (lat == 10) begin
                mult_op1 = 32'hFFFF_FFFF; mult_op2 = 32'hFFFF_FFFF; mult_begin = 1'b0;
            end
            @(posedge clk); lat++; @(negedge clk);
        end
        checks++;
        if (product !== 64'h0000_0000_0001_2340 || lat != 32 || busy_drops != 0) begin
            errors++;
            $display("FAIL b2b_second: product=%h lat=%0d drops=%0d, required 12340/32/0", product, lat, busy_drops);
        end else $display("ok   b2b_second: product=%h latency=%0d", product, lat);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mult_end !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: mult_end=%b busy=%b, required 0/0", mult_end, busy);
        end else $display("ok   b2b_idle: no further job started");
    endtask

    task automatic test_reset_midrun();
        int spurious;
        @(negedge clk);
        mult_op1 = 32'h7; mult_op2 = 32'h9; mult_signed = 1'b0; mult_begin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mult_begin = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || mult_end !== 1'b0 || product !== 64'd0) begin
            errors++;
            $display("FAIL reset_midrun: busy=%b mult_end=%b product=%h, required 0/0/0", busy, mult_end, product);
        end else $display("ok   reset_midrun: job aborted");
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (mult_end === 1'b1 || busy === 1'b1) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL reset_no_end: activity cycles=%0d, required 0", spurious);
        end else $display("ok   reset_no_end: no completion after abort");
        check_job("after_reset_16x16", 32'h10, 32'h10, 1'b0, 64'h100);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic s;
        logic [63:0] p, exp;
        int lat;
        for (int i = 0; i < 300; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            if (i % 10 == 3) a = '0;
            if (i % 10 == 7) b = '0;
            exp = ref_mul(a, b, s);
            run_job(a, b, s, p, lat);
            checks++;
            if (p !== exp || lat != 32) begin
                errors++;
                $display("FAIL random_%0d: %h*%h s=%0d product=%h lat=%0d, required %h/32", i, a, b, s, p, lat, exp);
            end else $display("ok   random_%0d: %h * %h signed=%0d -> %h", i, a, b, s, p);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_extremes();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
